// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: the external SPI pins plus the transmit handshake
// and the receive-side status signals of the slave.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    // SPI link pins
    logic                  sck;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    // transmit buffer handshake
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    // receive side
    logic [DATA_WIDTH-1:0] data_out;
    logic                  new_data;
    logic                  busy;

    modport slave (
        input  sck, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, tx_underrun, data_out, new_data, busy
    );

    modport master (
        output sck, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, tx_underrun, data_out, new_data, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first. The external sck/ss_n/mosi are oversampled in
// the clk domain. Received words appear on data_out with a one-cycle new_data
// strobe. Reply words come from a one-entry buffer filled over valid/ready.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // synchronizer chains; the top bit of each chain is the usable value
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_prev;

    logic sck_s;
    logic ss_n_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;

    // FSM and datapath state
    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_rx;
    logic [DATA_WIDTH-1:0]  shift_tx;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   byte_done;
    logic                   rx_done;

    // one-entry transmit buffer
    logic [DATA_WIDTH-1:0]  buf_data;
    logic                   buf_full;
    logic                   tx_load;
    logic [DATA_WIDTH-1:0]  load_value;
    logic                   tx_accept;

    // registered outputs
    logic [DATA_WIDTH-1:0]  data_out_r;
    logic                   new_data_r;
    logic                   busy_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   tx_underrun_r;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_n_s = ss_n_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    // A word is pulled out of the buffer when the slave gets selected and on
    // the falling sck edge that follows a completed word.
    assign tx_load    = ((state == IDLE) && !ss_n_s) ||
                        ((state == ACTIVE) && !ss_n_s && sck_fall && byte_done);
    assign load_value = buf_full ? buf_data : '0;
    assign tx_accept  = bus.tx_valid & ~buf_full;

    assign bus.tx_ready    = ~buf_full;
    assign bus.data_out    = data_out_r;
    assign bus.new_data    = new_data_r;
    assign bus.busy        = busy_r;
    assign bus.miso        = miso_r;
    assign bus.miso_oe     = miso_oe_r;
    assign bus.tx_underrun = tx_underrun_r;

    // Synchronize the asynchronous SPI pins and keep the previous sck sample
    // for edge detection. Resets to the deselected, clock-low bus state.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // in the chain samples its predecessor's value from before the edge.
        if (rst) begin
            sck_sync  <= '0;
            ss_n_sync <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], bus.ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_prev  <= sck_s;
        end
    end

    // Transmit buffer: filled by the handshake, emptied by a load. A load and
    // an accept never collide because accept needs the buffer empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data <= '0;
            buf_full <= 1'b0;
        end else if (tx_accept) begin
            buf_data <= bus.tx_data;
            buf_full <= 1'b1;
        end else if (tx_load) begin
            buf_full <= 1'b0;
        end
    end

    // Transfer FSM with shift registers, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift_rx      <= '0;
            shift_tx      <= '0;
            bit_cnt       <= '0;
            byte_done     <= 1'b0;
            rx_done       <= 1'b0;
            data_out_r    <= '0;
            new_data_r    <= 1'b0;
            busy_r        <= 1'b0;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            new_data_r    <= 1'b0;
            tx_underrun_r <= 1'b0;
            rx_done       <= 1'b0;

            // a word completed last cycle is published even if ss_n has
            // risen in between
            if (rx_done) begin
                data_out_r <= shift_rx;
                new_data_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!ss_n_s) begin
                        state         <= ACTIVE;
                        busy_r        <= 1'b1;
                        miso_oe_r     <= 1'b1;
                        shift_tx      <= load_value;
                        miso_r        <= load_value[DATA_WIDTH-1];
                        tx_underrun_r <= ~buf_full;
                        bit_cnt       <= '0;
                        byte_done     <= 1'b0;
                    end
                end

                ACTIVE: begin
                    if (ss_n_s) begin
                        // deselect: partial word and loaded reply are dropped
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                        miso_r    <= 1'b0;
                        bit_cnt   <= '0;
                        byte_done <= 1'b0;
                    end else if (sck_rise) begin
                        shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt   <= '0;
                            byte_done <= 1'b1;
                            rx_done   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (byte_done) begin
                            shift_tx      <= load_value;
                            miso_r        <= load_value[DATA_WIDTH-1];
                            tx_underrun_r <= ~buf_full;
                            byte_done     <= 1'b0;
                        end else begin
                            shift_tx <= shift_tx << 1;
                            miso_r   <= shift_tx[DATA_WIDTH-2];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives directed words, the
// expected received words go into a scoreboard queue that a monitor drains
// on every new_data strobe.
module tb_spi_slave;
    logic clk;
    logic rst;

    spi_slave_if #(.DATA_WIDTH(8)) bus();

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int underrun_cnt = 0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: compare every received word against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_underrun) underrun_cnt++;
            if (bus.new_data) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_new_data: got data_out=%0h, expected no strobe (t=%0t)",
                             bus.data_out, $time);
                end else begin
                    check("data_out", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] v);
        int budget = 200;
        while (!bus.tx_ready && budget > 0) begin
            wait_clks(1);
            budget--;
        end
        check("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        wait_clks(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic ss_start();
        bus.ss_n = 1'b0;
        wait_clks(4);
    endtask

    task automatic ss_end();
        wait_clks(4);
        bus.ss_n = 1'b1;
        wait_clks(8);
    endtask

    // mode-0 master: mosi set while sck low, miso sampled just before rise
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            wait_clks(4);
            mi = {mi[6:0], bus.miso};
            bus.sck = 1'b1;
            wait_clks(4);
            bus.sck = 1'b0;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;
        int uc0;

        rst = 1'b1;
        bus.sck = 1'b0;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);

        // 1: reset values
        check("rst_miso", {31'd0, bus.miso}, 32'd0);
        check("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_new_data", {31'd0, bus.new_data}, 32'd0);
        check("rst_underrun", {31'd0, bus.tx_underrun}, 32'd0);
        check("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);

        // 2: preloaded reply A5, receive 3C
        tx_write(8'hA5);
        check("t2_tx_ready_full", {31'd0, bus.tx_ready}, 32'd0);
        uc0 = underrun_cnt;
        exp_q.push_back(8'h3C);
        ss_start();
        check("t2_busy", {31'd0, bus.busy}, 32'd1);
        check("t2_miso_oe", {31'd0, bus.miso_oe}, 32'd1);
        check("t2_tx_ready_after_load", {31'd0, bus.tx_ready}, 32'd1);
        spi_xfer(8'h3C, 8, mi);
        check("t2_miso", {24'd0, mi}, 32'hA5);
        ss_end();
        check("t2_underrun_end", underrun_cnt - uc0, 32'd1);
        check("t2_drained", exp_q.size(), 32'd0);

        // 3: back-to-back words, second reply written mid-word
        tx_write(8'h11);
        uc0 = underrun_cnt;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        ss_start();
        fork
            spi_xfer(8'hF0, 8, mi);
            begin
                wait_clks(20);
                tx_write(8'h22);
            end
        join
        spi_xfer(8'h0F, 8, mi2);
        check("t3_miso_first", {24'd0, mi}, 32'h11);
        check("t3_miso_second", {24'd0, mi2}, 32'h22);
        ss_end();
        check("t3_underrun_end", underrun_cnt - uc0, 32'd1);
        check("t3_drained", exp_q.size(), 32'd0);
        check("t3_data_out", {24'd0, bus.data_out}, 32'h0F);

        // 4: empty buffer -> zeros and underrun at select
        uc0 = underrun_cnt;
        exp_q.push_back(8'h81);
        ss_start();
        check("t4_underrun_start", underrun_cnt - uc0, 32'd1);
        spi_xfer(8'h81, 8, mi);
        check("t4_miso_zero", {24'd0, mi}, 32'h00);
        ss_end();
        check("t4_underrun_total", underrun_cnt - uc0, 32'd2);
        check("t4_drained", exp_q.size(), 32'd0);

        // 5: aborted partial word, then a full word
        ss_start();
        spi_xfer(8'hFF, 5, mi);
        ss_end();
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_data_out_kept", {24'd0, bus.data_out}, 32'h81);
        exp_q.push_back(8'h55);
        ss_start();
        spi_xfer(8'h55, 8, mi);
        ss_end();
        check("t5_data_out", {24'd0, bus.data_out}, 32'h55);
        check("t5_drained", exp_q.size(), 32'd0);

        // 6: reset mid-word clears outputs and the buffered word
        tx_write(8'h77);
        ss_start();
        spi_xfer(8'h00, 3, mi);
        check("t6_miso_partial", {24'd0, mi}, 32'h03);
        tx_write(8'h66);
        check("t6_buffer_full", {31'd0, bus.tx_ready}, 32'd0);
        rst = 1'b1;
        bus.ss_n = 1'b1;
        bus.sck = 1'b0;
        wait_clks(1);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("t6_miso", {31'd0, bus.miso}, 32'd0);
        check("t6_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        check("t6_data_out", {24'd0, bus.data_out}, 32'h00);
        rst = 1'b0;
        wait_clks(4);
        uc0 = underrun_cnt;
        exp_q.push_back(8'hC3);
        ss_start();
        spi_xfer(8'hC3, 8, mi);
        check("t6_buffer_lost", {24'd0, mi}, 32'h00);
        ss_end();
        check("t6_underrun", underrun_cnt - uc0, 32'd2);
        check("t6_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
